brew_controller: RTL
====================

// Module: brew_controller
// PURPOSE
//  Drink-dispensing sequencer downstream of the coin counter (Contador). Consumes the
//  4-bit credit total and the debounced selection/cancel pulses. Checks price, clears
//  credit, reports change, then times the brew stages (cup, heat, pour, milk) that
//  drive the machine LEDs/actuators. Sits beside seven_segment in the top level.
// PARAMETERS
//  PRICE_ESPRESSO  3           espresso price, credit units (100 colones each)
//  PRICE_LATTE     5           latte price, credit units
//  T_CUP           50_000_000  cycles in CUP stage
//  T_HEAT          100_000_000 cycles in HEAT stage
//  T_POUR          100_000_000 cycles in POUR stage
//  T_MILK          50_000_000  cycles in MILK stage (latte only)
//  T_ERR           25_000_000  cycles err stays high after a rejected request
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous reset, active-low
//  total         in   4  current credit from Contador, unsigned
//  sel_espresso  in   1  one-cycle request pulse (debounced signal_up)
//  sel_latte     in   1  one-cycle request pulse
//  cancel        in   1  one-cycle refund request
//  clear_credit  out  1  one-cycle pulse; drives Contador reset
//  change        out  4  change/refund amount, held until next accept/cancel
//  change_valid  out  1  one-cycle pulse when change is updated
//  cup,heater,pump,milk out 1 each  stage actuators, one-hot, high only in own stage
//  busy          out  1  high in every state except IDLE and ERR
//  err           out  1  high in ERR
//  stage         out  3  state code for display/LEDs
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; all outputs 0; change=0; timer=0.
//  - States: IDLE, ERR, CUP, HEAT, POUR, MILK, DONE. Codes 0..6 in that order.
//  - IDLE: exactly one select high -> price = matching param.
//    total>=price: same edge latch drink type, change<=total-price (4-bit, no wrap
//    possible), pulse clear_credit and change_valid next cycle, go CUP.
//    total<price: go ERR, credit untouched.
//  - Both selects in same cycle -> ERR (ambiguous), no credit action.
//  - cancel in IDLE: change<=total, pulse change_valid + clear_credit; stays IDLE.
//    cancel with total=0: change_valid still pulses, change=0.
//  - cancel coincident with a select: cancel wins, select ignored.
//  - ERR: err=1 for T_ERR cycles then IDLE; selects ignored; cancel accepted
//    (refund as in IDLE, exits ERR to IDLE immediately).
//  - CUP->HEAT->POUR->(latte: MILK)->DONE; each stage lasts exactly T_x cycles
//    (timer loads T_x-1 on entry, counts down, advances at 0).
//  - DONE: one cycle, returns to IDLE; total brew latency from accept edge =
//    T_CUP+T_HEAT+T_POUR(+T_MILK)+1 cycles.
//  - While busy: sel_*, cancel ignored and not queued; credit inserted meanwhile
//    accumulates in Contador for the next drink.
//  - Coin pulse coincident with clear_credit is lost (Contador reset wins); accepted.
//  - rst_n asserted mid-brew: all actuators drop immediately (async), back to IDLE.
//  - Only one actuator output high at any time; none high in IDLE/ERR/DONE.
// STRUCTURE
//  - coffee_pkg.vh: state code localparams, default prices, credit width (4).
//  - Sub-module stage_timer: 32-bit loadable down-counter (load, value, zero flag),
//    clk/rst_n same as parent. FSM + output decode stay in brew_controller.
// TESTING  (bench overrides T_CUP=4,T_HEAT=6,T_POUR=5,T_MILK=3,T_ERR=8)
//  1 total=4, sel_espresso -> clear_credit 1 pulse, change=1 + change_valid,
//    cup 4 / heater 6 / pump 5 cycles, milk never high, IDLE after 16 cycles.
//  2 total=5, sel_latte -> change=0, milk high 3 cycles after pump, busy 19 cycles.
//  3 total=2, sel_latte -> err high 8 cycles, no clear_credit, change unchanged.
//  4 total=7, cancel+sel_espresso same cycle -> change=7, clear_credit, stays IDLE.
//  5 sel_espresso + sel_latte same cycle (total=9) -> ERR, credit untouched.
//  6 rst_n low during HEAT -> heater 0 same cycle, stage=0; sel_* during busy ignored.

Source files
------------

// File: rtl/brew_controller_pkg.sv
// Shared definitions for the drink-dispensing sequencer.
//   - credit and timer widths
//   - default drink prices (credit units of 100 colones)
//   - state encoding; the numeric codes are exported on the stage port
//     for the display/LED logic, so their order is fixed.
package brew_controller_pkg;

  localparam int CREDIT_W = 4;
  localparam int TIMER_W  = 32;

  localparam int DEFAULT_PRICE_ESPRESSO = 3;
  localparam int DEFAULT_PRICE_LATTE    = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_CUP  = 3'd2,
    ST_HEAT = 3'd3,
    ST_POUR = 3'd4,
    ST_MILK = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/brew_controller_stage_timer.sv
// Loadable down-counter used to time the brew stages and the error hold.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (as parent)
//   load        - load load_value this cycle (takes priority over counting)
//   load_value  - value loaded on load
//   zero        - high while the count is 0; the count saturates at 0
module brew_controller_stage_timer
  import brew_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/brew_controller.sv
// Drink-dispensing sequencer. Takes the credit total from the coin counter
// and debounced select/cancel pulses, checks the price, clears the credit,
// reports change and then steps through the timed brew stages.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   total[3:0]                 - current credit from the coin counter
//   sel_espresso, sel_latte    - one-cycle drink requests
//   cancel                     - one-cycle refund request
//   clear_credit               - one-cycle pulse, resets the coin counter
//   change[3:0]                - change/refund, held until next accept/cancel
//   change_valid               - one-cycle pulse when change is updated
//   cup, heater, pump, milk    - stage actuators, high only in own stage
//   busy                       - high in every state except IDLE and ERR
//   err                        - high while a rejected request is shown
//   stage[2:0]                 - current state code
module brew_controller
  import brew_controller_pkg::*;
#(
  parameter int unsigned PRICE_ESPRESSO = DEFAULT_PRICE_ESPRESSO,
  parameter int unsigned PRICE_LATTE    = DEFAULT_PRICE_LATTE,
  parameter int unsigned T_CUP          = 50_000_000,
  parameter int unsigned T_HEAT         = 100_000_000,
  parameter int unsigned T_POUR         = 100_000_000,
  parameter int unsigned T_MILK         = 50_000_000,
  parameter int unsigned T_ERR          = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CREDIT_W-1:0] total,
  input  logic                sel_espresso,
  input  logic                sel_latte,
  input  logic                cancel,
  output logic                clear_credit,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                cup,
  output logic                heater,
  output logic                pump,
  output logic                milk,
  output logic                busy,
  output logic                err,
  output logic [2:0]          stage
);

  localparam logic [CREDIT_W-1:0] PRICE_E = CREDIT_W'(PRICE_ESPRESSO);
  localparam logic [CREDIT_W-1:0] PRICE_L = CREDIT_W'(PRICE_LATTE);

  // The timer is loaded with T-1 on stage entry so a stage lasts exactly T cycles.
  localparam logic [TIMER_W-1:0] LOAD_CUP  = TIMER_W'(T_CUP - 1);
  localparam logic [TIMER_W-1:0] LOAD_HEAT = TIMER_W'(T_HEAT - 1);
  localparam logic [TIMER_W-1:0] LOAD_POUR = TIMER_W'(T_POUR - 1);
  localparam logic [TIMER_W-1:0] LOAD_MILK = TIMER_W'(T_MILK - 1);
  localparam logic [TIMER_W-1:0] LOAD_ERR  = TIMER_W'(T_ERR - 1);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] change_reg, change_next;
  logic                latte_reg, latte_next;
  // clear_credit and change_valid always fire together (accept or refund)
  logic                credit_pulse_reg, credit_pulse_next;

  logic                timer_load;
  logic [TIMER_W-1:0]  timer_value;
  logic                timer_zero;
  logic [CREDIT_W-1:0] price;

  brew_controller_stage_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      change_reg       <= '0;
      latte_reg        <= 1'b0;
      credit_pulse_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      change_reg       <= change_next;
      latte_reg        <= latte_next;
      credit_pulse_reg <= credit_pulse_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    change_next       = change_reg;
    latte_next        = latte_reg;
    credit_pulse_next = 1'b0;
    timer_load        = 1'b0;
    timer_value       = '0;
    price             = sel_latte ? PRICE_L : PRICE_E;

    unique case (state_reg)
      ST_IDLE: begin
        // cancel outranks any select arriving in the same cycle
        if (cancel) begin
          change_next       = total;
          credit_pulse_next = 1'b1;
        end else if (sel_espresso && sel_latte) begin
          state_next  = ST_ERR;
          timer_load  = 1'b1;
          timer_value = LOAD_ERR;
        end else if (sel_espresso || sel_latte) begin
          if (total >= price) begin
            state_next        = ST_CUP;
            timer_load        = 1'b1;
            timer_value       = LOAD_CUP;
            latte_next        = sel_latte;
            change_next       = total - price;
            credit_pulse_next = 1'b1;
          end else begin
            state_next  = ST_ERR;
            timer_load  = 1'b1;
            timer_value = LOAD_ERR;
          end
        end
      end
      ST_ERR: begin
        if (cancel) begin
          state_next        = ST_IDLE;
          change_next       = total;
          credit_pulse_next = 1'b1;
        end else if (timer_zero) begin
          state_next = ST_IDLE;
        end
      end
      ST_CUP: begin
        if (timer_zero) begin
          state_next  = ST_HEAT;
          timer_load  = 1'b1;
          timer_value = LOAD_HEAT;
        end
      end
      ST_HEAT: begin
        if (timer_zero) begin
          state_next  = ST_POUR;
          timer_load  = 1'b1;
          timer_value = LOAD_POUR;
        end
      end
      ST_POUR: begin
        if (timer_zero) begin
          if (latte_reg) begin
            state_next  = ST_MILK;
            timer_load  = 1'b1;
            timer_value = LOAD_MILK;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_MILK: begin
        if (timer_zero) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Actuators decode straight from the state register so an asynchronous
  // reset drops them without waiting for a clock edge.
  assign cup          = (state_reg == ST_CUP);
  assign heater       = (state_reg == ST_HEAT);
  assign pump         = (state_reg == ST_POUR);
  assign milk         = (state_reg == ST_MILK);
  assign err          = (state_reg == ST_ERR);
  assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_ERR);
  assign stage        = state_reg;
  assign change       = change_reg;
  assign clear_credit = credit_pulse_reg;
  assign change_valid = credit_pulse_reg;

endmodule
